mac_tap_seq: RTL and testbench
==============================

# mac_tap_seq

Sequencer for the `MAC` array in the LeNet convolution and fully-connected datapath. It runs one output tile as a series of kernel taps. On each tap it pulses the MAC enable vector, presents the tap index used for image and kernel addressing, and selects a zero or fed-back partial sum. It spaces issues to cover the MAC pipeline latency and writes the tile result back on the last tap. It sits between the layer controller (start/done) and the `MAC` array plus its operand buffers.

## Interface
Parameters:
- `MAC_NUM`, 120, number of MAC lanes; width of `mac_en`.
- `MAC_LAT`, 3, cycles from `mac_en` to `result_vld`; minimum issue spacing.
- `TAP_W`, 5, width of tap count and index (max 31 taps).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a tile; sampled only in IDLE.
- `num_taps` in `TAP_W`: taps in this tile; latched on accepted `start`.
- `data_rdy` in 1: operands for the current `tap_idx` are valid at the MAC inputs.
- `result_vld` in 1: from `MAC`; result of an issued tap is present.
- `mac_en` out `MAC_NUM`: all-ones for one cycle per tap issue, else 0.
- `tap_idx` out `TAP_W`: current tap, for operand addressing.
- `psum_clr` out 1: high with the issue of tap 0; the partial-sum mux feeds 0 instead of fed-back `result`.
- `psum_ld` out 1: capture `result` into the feedback register; equals `result_vld` for non-last taps.
- `out_wr` out 1: write final `result` to the output buffer; equals `result_vld` for the last tap.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at tile end.

## Operation
- States:
  - IDLE: waits for `start`.
  - ISSUE: issues a tap.
  - WAIT: spaces issues.
  - DRAIN: waits for the last result.
  - FIN: pulses `done`.
- IDLE → ISSUE on `start` with `num_taps` ≥ 1. This latches `N = num_taps`, sets `tap_idx` = 0 and sets `busy`.
- `start` with `num_taps` = 0 goes IDLE → FIN. It pulses `done` with no issue and no `out_wr`.
- ISSUE with `data_rdy` = 1:
  - `mac_en` = all-ones and `psum_clr` = (`tap_idx` == 0).
  - If `tap_idx` == N-1, go to DRAIN; otherwise go to WAIT.
- ISSUE with `data_rdy` = 0: stay in ISSUE with `mac_en` = 0. There is no timeout.
- WAIT: a counter loads `MAC_LAT`-1 on issue and decrements. At zero, `tap_idx` increments and the state returns to ISSUE. The issue spacing is therefore at least `MAC_LAT` cycles.
- DRAIN: wait for `result_vld` while the last-tap flag is set. That cycle asserts `out_wr` and goes to FIN.
- FIN: `done` = 1 and `busy` = 0 next cycle. Return to IDLE.
- `psum_ld` = `result_vld` & (pending tap ≠ last). Pending-tap tracking uses a `MAC_LAT`-deep shift of issue and last flags, so `psum_ld` and `out_wr` are never both high.
- `result_vld` in IDLE or FIN is ignored and never causes `psum_ld` or `out_wr`.
- `start` while `busy` is ignored. `num_taps` changes mid-tile have no effect.

## Timing
- Reset values:
  - `mac_en` = 0, `tap_idx` = 0, `psum_clr` = 0, `psum_ld` = 0, `out_wr` = 0, `busy` = 0, `done` = 0.
  - State = IDLE; the flag shift register is cleared.
- Fast path, `start` at cycle 0 with `data_rdy` always high: tap k issues at cycle 1 + k·`MAC_LAT`.
- Last issue at cycle L gives `out_wr` at L+`MAC_LAT` and `done` at L+`MAC_LAT`+1.
- Tile length with `data_rdy` constantly high: N·`MAC_LAT` + 2 cycles from `start` to `done`.
- `data_rdy` stalls add cycles one-for-one.
- `rst` mid-tile: next cycle all outputs at reset values. Pending `result_vld` pulses from in-flight taps are ignored.
- All outputs are registered except `psum_ld` and `out_wr`. Those are `result_vld` gated by registered flags, zero-cycle latency.

## Structure
- Shared package/header `def_header.vh`:
  - `MAC_NUM`.
  - MAC latency constant `MAC_LAT` = 3.
  - FSM state encodings.
- One sub-module, `issue_pipe`: a `MAC_LAT`-deep shift register of {issued, last}. It produces the pending-tap flags aligned to `result_vld`.

## Test plan
- **Basic tile.** `num_taps` = 25, `data_rdy` = 1. Expect:
  - 25 `mac_en` pulses 3 cycles apart; `psum_clr` only on the first.
  - 24 `psum_ld` pulses and 1 `out_wr`.
  - `done` at cycle 77.
- **Stall.** `num_taps` = 4, `data_rdy` dropped for 5 cycles before tap 2. Expect:
  - Tap 2 issues 5 cycles late.
  - `tap_idx` stays at 2 during the stall.
  - `done` at cycle 19.
- **Degenerate counts.** `num_taps` = 0: `done` at cycle 2, no `mac_en`, no `out_wr`. `num_taps` = 1: one issue with `psum_clr`=1, `out_wr` at 4, `done` at 5.
- **Ignored `start`.** `start` pulsed mid-tile with a different `num_taps`. Expect it ignored; the tile completes with the original N.
- **Reset mid-tile.** `rst` after tap 3 issues, with `result_vld` still arriving. Expect:
  - All outputs zero the next cycle.
  - No `psum_ld` or `out_wr` from stale `result_vld`.
  - A new `start` with 2 taps completes normally.
- **Spurious valid.** `result_vld` asserted in IDLE. Expect no `psum_ld` or `out_wr`.

Source files
------------

// File: rtl/mac_tap_seq_pkg.sv
// Shared constants and FSM state type for the MAC tap sequencer.
package mac_tap_seq_pkg;

    localparam int unsigned MAC_NUM_DEF = 120;
    localparam int unsigned MAC_LAT_DEF = 3;
    localparam int unsigned TAP_W_DEF   = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

endpackage

// File: rtl/mac_tap_seq_issue_pipe.sv
// Shift register of {issued, last} flags, aligned so the final stage
// coincides with the MAC result_vld of the corresponding tap.
module issue_pipe
    import mac_tap_seq_pkg::*;
#(
    parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    input  logic i_last,
    output logic o_pend,
    output logic o_pend_last
);

    logic [MAC_LAT-1:0] r_iss;
    logic [MAC_LAT-1:0] r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss  <= '0;
            r_last <= '0;
        end else begin
            r_iss[0]  <= i_issue;
            r_last[0] <= i_issue & i_last;
            for (int unsigned k = 1; k < MAC_LAT; k++) begin
                r_iss[k]  <= r_iss[k-1];
                r_last[k] <= r_last[k-1];
            end
        end
    end

    assign o_pend      = r_iss[MAC_LAT-1];
    assign o_pend_last = r_last[MAC_LAT-1];

endmodule

// File: rtl/mac_tap_seq.sv
// Tap sequencer for the MAC array: issues one tile as a series of spaced
// kernel taps, steers the partial-sum feedback and writes back the result.
module mac_tap_seq
    import mac_tap_seq_pkg::*;
#(
    parameter int unsigned MAC_NUM = MAC_NUM_DEF,
    parameter int unsigned MAC_LAT = MAC_LAT_DEF,
    parameter int unsigned TAP_W   = TAP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TAP_W-1:0]   num_taps,
    input  logic               data_rdy,
    input  logic               result_vld,
    output logic [MAC_NUM-1:0] mac_en,
    output logic [TAP_W-1:0]   tap_idx,
    output logic               psum_clr,
    output logic               psum_ld,
    output logic               out_wr,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      CNT_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MAC_LAT - 1);

    state_t           r_state;
    logic [TAP_W-1:0] r_n;
    logic [TAP_W-1:0] r_tap_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_issue;
    logic             r_iss_last;
    logic             r_psum_clr;
    logic             r_busy;
    logic             r_done;

    logic [TAP_W-1:0] w_n;
    logic             w_accept;
    logic             w_issue;
    logic             w_last;
    logic             w_active;
    logic             w_pend;
    logic             w_pend_last;
    state_t           w_post_issue;

    // Tap 0 issues on the same edge that accepts start, so the registered
    // mac_en of the first tap appears in the cycle right after start.
    always_comb begin
        w_accept     = (r_state == S_IDLE) && start && (num_taps != '0);
        w_n          = (r_state == S_IDLE) ? num_taps : r_n;
        w_last       = (r_tap_idx == (w_n - TAP_W'(1)));
        w_issue      = data_rdy && (w_accept || (r_state == S_ISSUE));
        w_post_issue = !w_issue ? S_ISSUE : (w_last ? S_DRAIN : S_WAIT);
        w_active     = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_DRAIN);
    end

    issue_pipe #(
        .MAC_LAT(MAC_LAT)
    ) u_issue_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (r_issue),
        .i_last     (r_iss_last),
        .o_pend     (w_pend),
        .o_pend_last(w_pend_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_tap_idx  <= '0;
            r_cnt      <= '0;
            r_issue    <= 1'b0;
            r_iss_last <= 1'b0;
            r_psum_clr <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_issue    <= w_issue;
            r_iss_last <= w_issue && w_last;
            r_psum_clr <= w_issue && (r_tap_idx == '0);
            if (w_issue) begin
                r_cnt <= LAT_M1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= num_taps;
                        r_busy  <= 1'b1;
                        r_state <= (num_taps == '0) ? S_FIN : w_post_issue;
                    end
                end
                S_ISSUE: r_state <= w_post_issue;
                S_WAIT: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state   <= S_ISSUE;
                        r_tap_idx <= r_tap_idx + TAP_W'(1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_wr) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    // An empty tile enters FIN without done; raise it here once.
                    if (r_done) begin
                        r_done    <= 1'b0;
                        r_tap_idx <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mac_en   = {MAC_NUM{r_issue}};
    assign tap_idx  = r_tap_idx;
    assign psum_clr = r_psum_clr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign psum_ld  = result_vld && w_active && w_pend && !w_pend_last;
    assign out_wr   = result_vld && w_active && w_pend && w_pend_last;

endmodule

// File: tb/tb_mac_tap_seq.sv
// Directed bench for mac_tap_seq: per-cycle comparison against an event-level
// model of the tile schedule, plus hand-computed pins on key cycles and counts.
module tb_mac_tap_seq;

    localparam int MN   = 120;
    localparam int LAT  = 3;
    localparam int TW   = 5;
    localparam int MAXC = 96;

    logic          clk;
    logic          rst;
    logic          start;
    logic [TW-1:0] num_taps;
    logic          data_rdy;
    logic          result_vld;
    logic [MN-1:0] mac_en;
    logic [TW-1:0] tap_idx;
    logic          psum_clr;
    logic          psum_ld;
    logic          out_wr;
    logic          busy;
    logic          done;

    mac_tap_seq #(
        .MAC_NUM(MN),
        .MAC_LAT(LAT),
        .TAP_W  (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_taps  (num_taps),
        .data_rdy  (data_rdy),
        .result_vld(result_vld),
        .mac_en    (mac_en),
        .tap_idx   (tap_idx),
        .psum_clr  (psum_clr),
        .psum_ld   (psum_ld),
        .out_wr    (out_wr),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // test configuration
    string tname;
    int    m_n, alt_n, st_tap, st_len, alt_at, rst_at, spur_from, spur_len;
    bit    m_start;

    // model expectations and drive tables, indexed by cycle from start
    bit e_mac [MAXC];
    bit e_clr [MAXC];
    bit e_ld  [MAXC];
    bit e_wr  [MAXC];
    bit e_busy[MAXC];
    bit e_done[MAXC];
    int e_idx [MAXC];
    bit drdy  [MAXC];
    bit rv    [MAXC];
    int model_done;

    // observations
    int cnt_mac, cnt_clr, cnt_ld, cnt_wr, cnt_post, done_cyc, wr_cyc;
    int mac_q[$];
    int idx_at[MAXC];

    // Schedule model: a tap may be decided at its eligible cycle or later
    // (first cycle with data_rdy); mac_en follows one cycle after the
    // decision, the result LAT cycles after mac_en, and the next tap is
    // eligible LAT cycles after the previous decision.
    task automatic setup(input string nm, input bit s, input int n, input int stap, input int slen,
                         input int aat, input int an, input int rat, input int sfrom, input int slen2);
        int dec, e, last_iss;
        int from_c[32];
        tname = nm; m_start = s; m_n = n; st_tap = stap; st_len = slen;
        alt_at = aat; alt_n = an; rst_at = rat; spur_from = sfrom; spur_len = slen2;
        for (int c = 0; c < MAXC; c++) begin
            e_mac[c] = 0; e_clr[c] = 0; e_ld[c] = 0; e_wr[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_idx[c] = 0; drdy[c] = 1; rv[c] = 0;
        end
        model_done = -1;
        last_iss = 0;
        if (m_start) begin
            if (m_n == 0) begin
                model_done = 2;
            end else begin
                e = 0;
                for (int k = 0; k < m_n; k++) begin
                    from_c[k] = e;
                    if (k == st_tap) begin
                        for (int j = 0; j < st_len; j++) drdy[e + j] = 0;
                        dec = e + st_len;
                    end else begin
                        dec = e;
                    end
                    e_mac[dec + 1] = 1;
                    if (k == 0) e_clr[dec + 1] = 1;
                    rv[dec + 1 + LAT] = 1;
                    if (k == m_n - 1) begin
                        e_wr[dec + 1 + LAT] = 1;
                        last_iss = dec + 1;
                    end else begin
                        e_ld[dec + 1 + LAT] = 1;
                    end
                    e = dec + LAT;
                end
                model_done = last_iss + LAT + 1;
                for (int c = 0; c <= model_done; c++)
                    for (int k = 0; k < m_n; k++)
                        if (from_c[k] <= c) e_idx[c] = k;
            end
            for (int c = 1; c < model_done; c++) e_busy[c] = 1;
            e_done[model_done] = 1;
        end
        for (int j = 0; j < spur_len; j++) rv[spur_from + j] = 1;
        if (rst_at >= 0) begin
            for (int c = rst_at + 1; c < MAXC; c++) begin
                e_mac[c] = 0; e_clr[c] = 0; e_ld[c] = 0; e_wr[c] = 0;
                e_busy[c] = 0; e_done[c] = 0; e_idx[c] = 0;
            end
        end
    endtask

    task automatic lit(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic compare_cycle(input int c);
        logic [9:0]    got_f;
        logic [9:0]    want_f;
        logic [MN-1:0] want_m;
        got_f  = {psum_clr, psum_ld, out_wr, busy, done, tap_idx};
        want_f = {e_clr[c], e_ld[c], e_wr[c], e_busy[c], e_done[c], 5'(e_idx[c])};
        want_m = {MN{e_mac[c]}};
        checks++;
        if (got_f !== want_f || mac_en !== want_m) begin
            errors++;
            $display("FAIL %s cyc %0d: mac_en=%h want %h, clr/ld/wr/busy/done/idx=%b want %b",
                     tname, c, mac_en, want_m, got_f, want_f);
        end
        if (mac_en[0]) begin cnt_mac++; mac_q.push_back(c); end
        if (psum_clr) cnt_clr++;
        if (psum_ld) cnt_ld++;
        if (out_wr) begin cnt_wr++; if (wr_cyc < 0) wr_cyc = c; end
        if (done && done_cyc < 0) done_cyc = c;
        if (rst_at >= 0 && c > rst_at && (psum_ld || out_wr)) cnt_post++;
        idx_at[c] = int'(tap_idx);
    endtask

    task automatic run(input int len);
        cnt_mac = 0; cnt_clr = 0; cnt_ld = 0; cnt_wr = 0; cnt_post = 0;
        done_cyc = -1; wr_cyc = -1;
        mac_q.delete();
        for (int c = 0; c < len; c++) begin
            rst        = (c == rst_at);
            start      = (m_start && c == 0) || (c == alt_at);
            num_taps   = (c == 0) ? 5'(m_n) : 5'(alt_n);
            data_rdy   = drdy[c];
            result_vld = rv[c];
            @(negedge clk);
            compare_cycle(c);
            @(posedge clk);
            #1;
        end
        rst = 0; start = 0; result_vld = 0;
    endtask

    initial begin
        rst = 1; start = 0; num_taps = '0; data_rdy = 0; result_vld = 0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_flags", int'({psum_clr, psum_ld, out_wr, busy, done, tap_idx}), 0);
        lit("reset_mac_en", int'(|mac_en), 0);

        setup("basic25", 1, 25, -1, 0, -1, 25, -1, 0, 0);
        run(model_done + 3);
        lit("basic_mac_cnt", cnt_mac, 25);
        lit("basic_clr_cnt", cnt_clr, 1);
        lit("basic_ld_cnt", cnt_ld, 24);
        lit("basic_wr_cnt", cnt_wr, 1);
        lit("basic_done_cyc", done_cyc, 77);

        setup("stall4", 1, 4, 2, 5, -1, 4, -1, 0, 0);
        run(model_done + 3);
        lit("stall_tap2_cyc", (mac_q.size() > 2) ? mac_q[2] : -1, 12);
        lit("stall_idx_hold", idx_at[9], 2);
        lit("stall_done_cyc", done_cyc, 19);

        setup("taps0", 1, 0, -1, 0, -1, 0, -1, 0, 0);
        run(6);
        lit("n0_done_cyc", done_cyc, 2);
        lit("n0_mac_cnt", cnt_mac, 0);
        lit("n0_wr_cnt", cnt_wr, 0);

        setup("taps1", 1, 1, -1, 0, -1, 1, -1, 0, 0);
        run(model_done + 3);
        lit("n1_clr_cnt", cnt_clr, 1);
        lit("n1_wr_cyc", wr_cyc, 4);
        lit("n1_done_cyc", done_cyc, 5);

        setup("ign_start", 1, 3, -1, 0, 2, 9, -1, 0, 0);
        run(model_done + 3);
        lit("ign_mac_cnt", cnt_mac, 3);
        lit("ign_done_cyc", done_cyc, 11);

        setup("rst_mid", 1, 6, -1, 0, -1, 6, 11, 0, 0);
        run(18);
        lit("rst_stale_ld_wr", cnt_post, 0);
        lit("rst_mac_cnt", cnt_mac, 4);

        setup("after_rst", 1, 2, -1, 0, -1, 2, -1, 0, 0);
        run(model_done + 3);
        lit("after_rst_done", done_cyc, 8);
        lit("after_rst_wr", cnt_wr, 1);

        setup("spurious", 0, 0, -1, 0, -1, 0, -1, 1, 4);
        run(8);
        lit("spur_ld_cnt", cnt_ld, 0);
        lit("spur_wr_cnt", cnt_wr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
